// File: rtl/reg_op_pkg.sv
// Shared types for the register-op sequencer: opcode and FSM state encodings.
package reg_op_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MOV = 3'b101,
        OP_LDI = 3'b110,
        OP_NOP = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ_A = 2'd1,
        ST_READ_B = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    // LDI and NOP never touch the read port.
    function automatic logic needs_read(input op_t op);
        return (op != OP_LDI) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/reg_op_alu.sv
// Combinational datapath for the sequencer.
// Ports: op_i opcode, a_i/b_i operands, imm_i immediate,
//        result_o modulo-2^W result, carry_o carry (ADD) or borrow (SUB).
module reg_op_alu
    import reg_op_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  op_t                   op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o
);

    logic [DATA_WIDTH:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[DATA_WIDTH-1:0];
                carry_o  = sum[DATA_WIDTH];
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                carry_o  = (a_i < b_i);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_MOV:  result_o = a_i;
            OP_LDI:  result_o = imm_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// Command-driven micro-sequencer in front of a single-read/single-write register file.
// Ports: clk/reset (sync, active high); cmd_* valid/ready command channel;
//        rf_r_addr/rf_r_data serial operand reads; rf_w_* write-back;
//        busy/done status; flag_zero/flag_carry result flags.
module reg_op_sequencer
    import reg_op_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_rs1,
    input  logic [ADDR_WIDTH-1:0] cmd_rs2,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [ADDR_WIDTH-1:0] rf_r_addr,
    input  logic [DATA_WIDTH-1:0] rf_r_data,
    output logic                  rf_w_en,
    output logic [ADDR_WIDTH-1:0] rf_w_addr,
    output logic [DATA_WIDTH-1:0] rf_w_data,
    output logic                  busy,
    output logic                  done,
    output logic                  flag_zero,
    output logic                  flag_carry
);

    state_t                  state_q;
    op_t                     op_q;
    logic [ADDR_WIDTH-1:0]   rd_q;
    logic [ADDR_WIDTH-1:0]   rs2_q;
    logic [DATA_WIDTH-1:0]   op_a_q;
    logic                    res_carry_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic                    w_en_q;
    logic [ADDR_WIDTH-1:0]   w_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic                    zero_q;
    logic                    carry_q;

    op_t                     cmd_op_e;
    op_t                     alu_op;
    logic [DATA_WIDTH-1:0]   alu_a;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_carry;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    go_write;

    assign cmd_op_e = op_t'(cmd_op);

    // Result is computed on the edge entering WRITE, so the ALU sees the
    // operand arriving on the read port that same cycle (or the live command
    // for LDI/NOP, which go straight from IDLE).
    always_comb begin
        alu_op   = op_q;
        alu_a    = op_a_q;
        wr_addr  = rd_q;
        go_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                alu_op   = cmd_op_e;
                wr_addr  = cmd_rd;
                go_write = cmd_valid && !needs_read(cmd_op_e);
            end
            ST_READ_A: begin
                alu_a    = rf_r_data;
                go_write = (op_q == OP_MOV);
            end
            ST_READ_B: go_write = 1'b1;
            default:   go_write = 1'b0;
        endcase
    end

    reg_op_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (rf_r_data),
        .imm_i    (cmd_imm),
        .result_o (alu_res),
        .carry_o  (alu_carry)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            rd_q        <= '0;
            rs2_q       <= '0;
            op_a_q      <= '0;
            res_carry_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            r_addr_q    <= '0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op_e;
                        rd_q    <= cmd_rd;
                        rs2_q   <= cmd_rs2;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (needs_read(cmd_op_e)) begin
                            r_addr_q <= cmd_rs1;
                            state_q  <= ST_READ_A;
                        end
                    end
                end
                ST_READ_A: begin
                    op_a_q <= rf_r_data;
                    if (op_q != OP_MOV) begin
                        r_addr_q <= rs2_q;
                        state_q  <= ST_READ_B;
                    end
                end
                ST_READ_B: begin
                    state_q <= ST_WRITE;
                end
                default: begin
                    // Write commits on this edge; flags follow it.
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    w_en_q  <= 1'b0;
                    if (op_q != OP_NOP) begin
                        zero_q  <= (w_data_q == '0);
                        carry_q <= res_carry_q;
                    end
                end
            endcase
            if (go_write) begin
                state_q     <= ST_WRITE;
                done_q      <= 1'b1;
                w_en_q      <= (alu_op != OP_NOP);
                w_addr_q    <= wr_addr;
                w_data_q    <= alu_res;
                res_carry_q <= alu_carry;
            end
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rf_r_addr  = r_addr_q;
    // A pending write is suppressed immediately while reset is asserted.
    assign rf_w_en    = w_en_q & ~reset;
    assign rf_w_addr  = w_addr_q;
    assign rf_w_data  = w_data_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench: sequencer driving a 4 x 8-bit register file model.
module tb_reg_op_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [DW-1:0] cmd_imm;
    logic [AW-1:0] rf_r_addr;
    logic [DW-1:0] rf_r_data;
    logic          rf_w_en;
    logic [AW-1:0] rf_w_addr;
    logic [DW-1:0] rf_w_data;
    logic          busy, done, flag_zero, flag_carry;

    logic [DW-1:0] rf [4];

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_regs [4];
    bit m_zero;
    bit m_carry;

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_w_en) rf[rf_w_addr] <= rf_w_data;
    assign rf_r_data = rf[rf_r_addr];

    reg_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .rf_r_addr  (rf_r_addr),
        .rf_r_data  (rf_r_data),
        .rf_w_en    (rf_w_en),
        .rf_w_addr  (rf_w_addr),
        .rf_w_data  (rf_w_data),
        .busy       (busy),
        .done       (done),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Architectural effect of one command, from the opcode table.
    task automatic model_step(input int op, input int rd, input int rs1, input int rs2,
                              input int imm, output bit we, output int data, output int lat);
        int a, b, r;
        bit c;
        a = m_regs[rs1];
        b = m_regs[rs2];
        c = 1'b0;
        r = 0;
        case (op)
            0: begin r = a + b; c = (r > 255); end
            1: begin r = a - b; c = (a < b); if (r < 0) r += 256; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a;
            6: r = imm;
            default: r = 0;
        endcase
        data = r % 256;
        lat  = (op < 5) ? 3 : (op == 5) ? 2 : 1;
        we   = (op != 7);
        if (we) begin
            m_regs[rd] = data;
            m_zero     = (data == 0);
            m_carry    = c;
        end
    endtask

    task automatic scramble_inputs();
        cmd_op  = 3'($urandom);
        cmd_rd  = 2'($urandom);
        cmd_rs1 = 2'($urandom);
        cmd_rs2 = 2'($urandom);
        cmd_imm = 8'($urandom);
    endtask

    // Issue one command from a negedge and follow it to completion.
    task automatic run_cmd(input string tag, input int op, input int rd, input int rs1,
                           input int rs2, input int imm, input bit exp_we, input int exp_data,
                           input bit exp_zero, input bit exp_carry, input int exp_lat);
        int waited = 0;
        int done_cyc = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_rd    = 2'(rd);
        cmd_rs1   = 2'(rs1);
        cmd_rs2   = 2'(rs2);
        cmd_imm   = 8'(imm);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        scramble_inputs();
        for (int cyc = 1; cyc <= 6 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            check({tag, "_busy"}, int'(busy), 1);
            check({tag, "_notready"}, int'(cmd_ready), 0);
            if (cyc == 1 && exp_lat >= 2) check({tag, "_raddr_a"}, int'(rf_r_addr), rs1);
            if (cyc == 2 && exp_lat == 3) check({tag, "_raddr_b"}, int'(rf_r_addr), rs2);
            if (done) begin
                done_cyc = cyc;
                check({tag, "_wen"}, int'(rf_w_en), int'(exp_we));
                if (exp_we) begin
                    check({tag, "_waddr"}, int'(rf_w_addr), rd);
                    check({tag, "_wdata"}, int'(rf_w_data), exp_data);
                end
            end else begin
                check({tag, "_wen_early"}, int'(rf_w_en), 0);
            end
        end
        check({tag, "_latency"}, done_cyc, exp_lat);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_idle_ready"}, int'(cmd_ready), 1);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_zero"}, int'(flag_zero), int'(exp_zero));
        check({tag, "_carry"}, int'(flag_carry), int'(exp_carry));
        if (exp_we) check({tag, "_rf"}, int'(rf[rd]), exp_data);
    endtask

    typedef struct {
        int op; int rd; int rs1; int rs2; int imm;
        bit we; int data; bit zero; bit carry; int lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        bit we;
        int data, lat, op;
        int rd, rs1, rs2, imm;

        vecs[0] = '{op:6, rd:0, rs1:0, rs2:0, imm:8'hFF, we:1, data:8'hFF, zero:0, carry:0, lat:1};
        vecs[1] = '{op:6, rd:1, rs1:0, rs2:0, imm:8'h01, we:1, data:8'h01, zero:0, carry:0, lat:1};
        vecs[2] = '{op:0, rd:2, rs1:0, rs2:1, imm:0,     we:1, data:8'h00, zero:1, carry:1, lat:3};
        vecs[3] = '{op:1, rd:3, rs1:1, rs2:0, imm:0,     we:1, data:8'h02, zero:0, carry:1, lat:3};
        vecs[4] = '{op:4, rd:3, rs1:3, rs2:3, imm:0,     we:1, data:8'h00, zero:1, carry:0, lat:3};
        vecs[5] = '{op:7, rd:1, rs1:2, rs2:3, imm:8'h5A, we:0, data:0,     zero:1, carry:0, lat:1};
        vecs[6] = '{op:5, rd:2, rs1:0, rs2:1, imm:0,     we:1, data:8'hFF, zero:0, carry:0, lat:2};

        m_zero  = 1'b0;
        m_carry = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        scramble_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wen_during", int'(rf_w_en), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wen", int'(rf_w_en), 0);
        check("rst_zero", int'(flag_zero), 0);
        check("rst_carry", int'(flag_carry), 0);
        check("rst_raddr", int'(rf_r_addr), 0);
        check("rst_waddr", int'(rf_w_addr), 0);
        check("rst_wdata", int'(rf_w_data), 0);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            model_step(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, we, data, lat);
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].imm, vecs[i].we, vecs[i].data, vecs[i].zero, vecs[i].carry, vecs[i].lat);
        end

        // Random commands against the model.
        for (int i = 0; i < 40; i++) begin
            op  = int'($urandom_range(0, 7));
            rd  = int'($urandom_range(0, 3));
            rs1 = int'($urandom_range(0, 3));
            rs2 = int'($urandom_range(0, 3));
            imm = int'($urandom_range(0, 255));
            model_step(op, rd, rs1, rs2, imm, we, data, lat);
            run_cmd($sformatf("rnd%0d", i), op, rd, rs1, rs2, imm, we, data, m_zero, m_carry, lat);
        end

        // Back-to-back ADD R0,R0,R0 with cmd_valid held high.
        model_step(6, 0, 0, 0, 3, we, data, lat);
        run_cmd("b2b_ldi", 6, 0, 0, 0, 3, 1'b1, 3, 1'b0, 1'b0, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_rd    = 2'd0;
        cmd_rs1   = 2'd0;
        cmd_rs2   = 2'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) model_step(0, 0, 0, 0, 0, we, data, lat);
            check($sformatf("b2b_ready%0d", i), int'(cmd_ready), int'(i == 0 || i == 4));
            check($sformatf("b2b_done%0d", i), int'(done), int'(i == 3 || i == 7));
            if (i == 3) begin
                check("b2b_wdata1", int'(rf_w_data), data);
                check("b2b_wdata1_abs", int'(rf_w_data), 8'h06);
                model_step(0, 0, 0, 0, 0, we, data, lat);
            end
            if (i == 7) begin
                check("b2b_wdata2", int'(rf_w_data), data);
                check("b2b_wdata2_abs", int'(rf_w_data), 8'h0C);
            end
            @(negedge clk);
            if (i == 4) cmd_valid = 1'b0;
        end
        check("b2b_r0", int'(rf[0]), 8'h0C);

        // Reset during READ_B drops the command.
        model_step(6, 2, 0, 0, 8'h55, we, data, lat);
        run_cmd("rst_ldi", 6, 2, 0, 0, 8'h55, 1'b1, 8'h55, 1'b0, 1'b0, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_rd    = 2'd2;
        cmd_rs1   = 2'd0;
        cmd_rs2   = 2'd1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rstmid_raddr_a", int'(rf_r_addr), 0);
        @(negedge clk);
        check("rstmid_raddr_b", int'(rf_r_addr), 1);
        check("rstmid_busy_b", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("rstmid_wen_b", int'(rf_w_en), 0);
        @(negedge clk);
        check("rstmid_wen_r", int'(rf_w_en), 0);
        check("rstmid_done_r", int'(done), 0);
        reset = 1'b0;
        m_zero  = 1'b0;
        m_carry = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rstmid_ready%0d", i), int'(cmd_ready), 1);
            check($sformatf("rstmid_busy%0d", i), int'(busy), 0);
            check($sformatf("rstmid_wen%0d", i), int'(rf_w_en), 0);
            @(negedge clk);
        end
        check("rstmid_zero", int'(flag_zero), int'(m_zero));
        check("rstmid_carry", int'(flag_carry), int'(m_carry));
        check("rstmid_r2", int'(rf[2]), 8'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
